// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit start validation, parity/framing/overrun flags and a one-entry holding register
module uart_rx_param #(
    parameter int DATA_W      = 8,
    parameter int OSR         = 16,
    parameter int DIV_W       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_en,
    input  logic              rx,
    input  logic [DIV_W-1:0]  baud_divisor,
    input  logic [1:0]        parity_mode,
    input  logic              stop_sel,
    input  logic              data_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              busy
);
    localparam int SW = $clog2(OSR);
    localparam int IW = $clog2(DATA_W);
    localparam logic [SW-1:0] S_HALF = SW'(OSR / 2 - 1);
    localparam logic [SW-1:0] S_FULL = SW'(OSR - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
    state_t state, state_d;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s, rx_d;
    logic [DIV_W-1:0]       tcnt, div;
    logic [SW-1:0]          scnt;
    logic [IW-1:0]          idx;
    logic [DATA_W-1:0]      shreg;
    logic [1:0]             pmode;
    logic                   two_stop, perr, ferr;
    logic                   tick, half, full, start_edge, commit, load, fin_ferr;

    assign rx_s       = sync[SYNC_STAGES-1];
    assign div        = (baud_divisor == '0) ? DIV_W'(1) : baud_divisor;
    assign tick       = (state != IDLE) && (tcnt == div - DIV_W'(1));
    assign half       = tick && (scnt == S_HALF);
    assign full       = tick && (scnt == S_FULL);
    assign start_edge = rx_en && rx_d && !rx_s;
    // final stop sample: the frame is handed over on this same edge
    assign commit     = rx_en && full && ((state == STOP1 && !two_stop) || state == STOP2);
    assign load       = commit && (!data_valid || data_ack);
    assign fin_ferr   = ferr | ~rx_s;
    assign busy       = state != IDLE;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start_edge ? START : IDLE;
            START:   state_d = half ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_d = (full && idx == I_LAST) ? ((pmode == 2'b01 || pmode == 2'b10) ? PARITY : STOP1) : DATA;
            PARITY:  state_d = full ? STOP1 : PARITY;
            STOP1:   state_d = full ? (two_stop ? STOP2 : IDLE) : STOP1;
            STOP2:   state_d = full ? IDLE : STOP2;
            default: state_d = IDLE;
        endcase
        if (!rx_en) state_d = IDLE;
    end

    always_ff @(posedge clk) state <= reset ? IDLE : state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= '1;
            rx_d     <= 1'b1;
            tcnt     <= '0;
            scnt     <= '0;
            idx      <= '0;
            shreg    <= '0;
            pmode    <= '0;
            two_stop <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
            rx_d <= rx_s;
            tcnt <= (state == IDLE || tick) ? '0 : tcnt + DIV_W'(1);
            scnt <= (state == IDLE || (state == START ? half : full)) ? '0 : scnt + SW'(tick);
            if (state == IDLE && start_edge) begin
                idx      <= '0;
                pmode    <= parity_mode;
                two_stop <= stop_sel;
                perr     <= 1'b0;
                ferr     <= 1'b0;
            end
            if (state == DATA && full) begin
                shreg[idx] <= rx_s;
                idx        <= idx + IW'(1);
            end
            // odd mode expects total parity 1, so invert the even-mode result
            if (state == PARITY && full) perr <= (^shreg ^ rx_s) ^ pmode[1];
            if (state == STOP1 && full) ferr <= ~rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= commit && !load;
            if (load) begin
                data_out   <= shreg;
                parity_err <= perr;
                frame_err  <= fin_ferr;
                data_valid <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: table-driven frame vectors plus hand-written timing, glitch, break, overrun, abort and reset sequences
module tb_uart_rx_param;
    logic        clk = 1'b0, reset = 1'b1, rx_en = 1'b0, rx = 1'b1, stop_sel = 1'b0, data_ack = 1'b0;
    logic [11:0] baud_divisor = 12'd4;
    logic [1:0]  parity_mode = 2'b00;
    logic [7:0]  data_out;
    logic        data_valid, parity_err, frame_err, overrun_err, busy;
    int          checks = 0, errors = 0;
    int          cyc = 0, ovr = 0, rise_cyc = 0, fall_cyc = 0, bitlen = 64, o = 0;
    logic        dv_q = 1'b0;

    typedef struct {
        logic [11:0] div;
        logic [7:0]  d;
        logic [1:0]  pm;
        logic        ss, p, s1, s2, perr, ferr;
    } vec_t;
    localparam int NV = 12;
    vec_t vt[NV];

    uart_rx_param dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .rx(rx), .baud_divisor(baud_divisor),
        .parity_mode(parity_mode), .stop_sel(stop_sel), .data_ack(data_ack), .data_out(data_out),
        .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (overrun_err) ovr <= ovr + 1;
        dv_q <= data_valid;
        if (data_valid && !dv_q) rise_cyc <= cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [15:0] b, input int n);
        fall_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            rx = b[i];
            repeat (bitlen) @(negedge clk);
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic [1:0] pm, input logic ss, input logic p,
                         input logic s1, input logic s2);
        logic [15:0] b;
        int n;
        parity_mode = pm;
        stop_sel = ss;
        b = 16'd0;
        b[8:1] = d;
        n = 9;
        if (pm == 2'b01 || pm == 2'b10) begin
            b[n] = p;
            n++;
        end
        b[n] = s1;
        n++;
        if (ss) begin
            b[n] = s2;
            n++;
        end
        send_bits(b, n);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_frame(input string name, input logic [7:0] d, input logic pe, input logic fe);
        check({name, " valid"}, data_valid, 1);
        check({name, " data"}, data_out, d);
        check({name, " perr"}, parity_err, pe);
        check({name, " ferr"}, frame_err, fe);
    endtask

    initial begin
        vt[0]  = '{12'd4, 8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{12'd4, 8'h03, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{12'd4, 8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{12'd4, 8'h07, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{12'd4, 8'h07, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{12'd4, 8'h5A, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{12'd4, 8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{12'd4, 8'h3C, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{12'd0, 8'h96, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{12'd1, 8'hE1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[10] = '{12'd4, 8'hFF, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[11] = '{12'd4, 8'h81, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst data", data_out, 0);
        check("rst valid", data_valid, 0);
        check("rst perr", parity_err, 0);
        check("rst ferr", frame_err, 0);
        check("rst ovr", overrun_err, 0);
        check("rst busy", busy, 0);
        rx_en = 1'b1;
        idle(8);

        for (int i = 0; i < NV; i++) begin
            baud_divisor = vt[i].div;
            bitlen = 16 * ((vt[i].div == 0) ? 1 : int'(vt[i].div));
            o = ovr;
            frame(vt[i].d, vt[i].pm, vt[i].ss, vt[i].p, vt[i].s1, vt[i].s2);
            idle(8);
            expect_frame($sformatf("v%0d", i), vt[i].d, vt[i].perr, vt[i].ferr);
            check($sformatf("v%0d ovr", i), ovr - o, 0);
            ack();
            check($sformatf("v%0d ack valid", i), data_valid, 0);
            check($sformatf("v%0d ack flags", i), {parity_err, frame_err}, 0);
            check($sformatf("v%0d ack data", i), data_out, vt[i].d);
            idle(8);
        end
        baud_divisor = 12'd4;
        bitlen = 64;

        fork
            frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                repeat (2) @(negedge clk);
                check("start detect early", busy, 0);
                @(negedge clk);
                check("start detect", busy, 1);
            end
        join
        idle(8);
        check("valid latency", rise_cyc - fall_cyc, 611);
        idle(200);
        expect_frame("held", 8'hA5, 0, 0);
        check("idle busy", busy, 0);
        ack();

        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch busy", busy, 1);
        repeat (10) @(negedge clk);
        idle(40);
        check("glitch busy drop", busy, 0);
        check("glitch valid", data_valid, 0);
        frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(8);
        expect_frame("after glitch", 8'h3C, 0, 0);
        ack();

        frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (128) @(negedge clk);
        expect_frame("break", 8'h5A, 0, 1);
        ack();
        repeat (64) @(negedge clk);
        check("break busy", busy, 0);
        check("break valid", data_valid, 0);
        idle(64);
        frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(8);
        expect_frame("after break", 8'hC3, 0, 0);
        ack();

        o = ovr;
        frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(8);
        frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(8);
        expect_frame("overrun", 8'h11, 0, 0);
        check("overrun pulse", ovr - o, 1);
        ack();
        check("overrun ack", data_valid, 0);
        frame(8'h33, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(8);
        expect_frame("after overrun", 8'h33, 0, 0);
        fork
            frame(8'h44, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                repeat (610) @(negedge clk);
                data_ack = 1'b1;
                @(negedge clk);
                data_ack = 1'b0;
            end
        join
        idle(8);
        expect_frame("ack at commit", 8'h44, 0, 0);
        check("ack at commit ovr", ovr - o, 1);

        fork
            frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                repeat (288) @(negedge clk);
                check("abort pre busy", busy, 1);
                rx_en = 1'b0;
                @(negedge clk);
                check("abort busy", busy, 0);
            end
        join
        idle(8);
        expect_frame("abort hold", 8'h44, 0, 0);
        check("abort ovr", ovr - o, 1);
        ack();
        check("ack disabled", data_valid, 0);
        rx_en = 1'b1;
        idle(8);

        fork
            frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
            begin
                repeat (100) @(negedge clk);
                parity_mode = 2'b00;
            end
        join
        idle(8);
        expect_frame("mode latched", 8'h03, 1, 0);
        fork
            frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                repeat (300) @(negedge clk);
                reset = 1'b1;
                rx_en = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                check("mid rst data", data_out, 0);
                check("mid rst valid", data_valid, 0);
                check("mid rst flags", {parity_err, frame_err, overrun_err}, 0);
                check("mid rst busy", busy, 0);
            end
        join
        idle(16);
        rx_en = 1'b1;
        idle(8);
        frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(8);
        expect_frame("after reset", 8'hC3, 0, 0);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
